// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if: write-port arbiter bus (pipeline A, queued B, rf write, hazard query)
interface regfile_wport_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                       a_wr;
    logic [ADDR_W-1:0]          a_addr;
    logic [DATA_W-1:0]          a_data;
    logic                       b_valid;
    logic [ADDR_W-1:0]          b_addr;
    logic [DATA_W-1:0]          b_data;
    logic                       b_ready;
    logic                       rf_wr;
    logic [ADDR_W-1:0]          rf_addr;
    logic [DATA_W-1:0]          rf_data;
    logic [ADDR_W-1:0]          pend_addr;
    logic                       pend_hit;
    logic                       stall_req;
    logic [$clog2(DEPTH):0]     q_count;

    modport master (
        output a_wr, a_addr, a_data, b_valid, b_addr, b_data, pend_addr,
        input  b_ready, rf_wr, rf_addr, rf_data, pend_hit, stall_req, q_count
    );

    modport slave (
        input  a_wr, a_addr, a_data, b_valid, b_addr, b_data, pend_addr,
        output b_ready, rf_wr, rf_addr, rf_data, pend_hit, stall_req, q_count
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares one register-file write port between pipeline A and a queued B path
module regfile_wport_arbiter #(
    parameter int DEPTH  = 4,
    parameter int STARVE = 8,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    regfile_wport_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE + 1);

    logic [ADDR_W-1:0] r_qaddr [DEPTH];
    logic [DATA_W-1:0] r_qdata [DEPTH];
    logic [DEPTH-1:0]  r_qvld;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_count;
    logic [WW-1:0]     r_wait;
    logic              r_rf_wr;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic              r_stall;

    logic              w_a_eff;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;
    logic [WW-1:0]     w_wait_nxt;
    logic [DEPTH-1:0]  w_match;
    logic [DEPTH-1:0]  w_vld_nxt;

    assign w_a_eff     = bus.a_wr && (bus.a_addr != '0);
    assign bus.b_ready = r_count != CW'(DEPTH);
    assign w_push      = bus.b_valid && bus.b_ready && (bus.b_addr != '0);
    assign w_pop       = !w_a_eff && (r_count != '0);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_wait_nxt  = (w_pop || r_count == '0) ? '0 :
                         (r_wait == WW'(STARVE)) ? r_wait : r_wait + WW'(1);

    // Entries present before this edge are killed by a same-address A write;
    // the slot being pushed at this edge is set afterwards, so the newer B wins.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign w_match[g]   = r_qvld[g] && (r_qaddr[g] == bus.pend_addr);
        assign w_vld_nxt[g] = (w_push && r_wp == PW'(g)) ||
                              (r_qvld[g] && !(w_a_eff && r_qaddr[g] == bus.a_addr) &&
                               !(w_pop && r_rp == PW'(g)));
    end

    assign bus.pend_hit  = (bus.pend_addr != '0) && |w_match;
    assign bus.rf_wr     = r_rf_wr;
    assign bus.rf_addr   = r_rf_addr;
    assign bus.rf_data   = r_rf_data;
    assign bus.stall_req = r_stall;
    assign bus.q_count   = r_count;

    // Queue payload storage; validity is tracked separately so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_qaddr[r_wp] <= bus.b_addr;
            r_qdata[r_wp] <= bus.b_data;
        end
    end

    // Queue control, wait counter, stall and the registered write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qvld    <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_wait    <= '0;
            r_rf_wr   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
            r_stall   <= 1'b0;
        end else begin
            r_qvld  <= w_vld_nxt;
            r_wp    <= r_wp + PW'(w_push);
            r_rp    <= r_rp + PW'(w_pop);
            r_count <= w_count_nxt;
            r_wait  <= w_wait_nxt;
            r_stall <= (w_count_nxt == CW'(DEPTH)) || (w_wait_nxt >= WW'(STARVE));
            if (w_a_eff) begin
                r_rf_wr   <= 1'b1;
                r_rf_addr <= bus.a_addr;
                r_rf_data <= bus.a_data;
            end else if (w_pop && r_qvld[r_rp]) begin
                r_rf_wr   <= 1'b1;
                r_rf_addr <= r_qaddr[r_rp];
                r_rf_data <= r_qdata[r_rp];
            end else begin
                r_rf_wr <= 1'b0;
            end
        end
    end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between two writers.
- Port A is the main pipeline writeback. It has fixed priority and cannot be back-pressured.
- Port B is the long-latency unit (mult/div) result path. Its writes are buffered in a small ordered queue.
- The block also provides a pending-write scoreboard query for decode hazard checks, and a stall request so the pipeline can drain B when the queue is full or starving.

Parameters:
- DEPTH, 4, number of port-B queue entries (power of 2, ≥2).
- STARVE, 8, cycles the queue head may wait before a stall is requested.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- a_wr  in  1  pipeline writeback enable.
- a_addr  in  ADDR_W  pipeline writeback register index.
- a_data  in  DATA_W  pipeline writeback data.
- b_valid  in  1  B write request.
- b_addr  in  ADDR_W  B register index.
- b_data  in  DATA_W  B data.
- b_ready  out  1  queue can accept; transfer occurs when b_valid && b_ready.
- rf_wr  out  1  register file write enable (registered).
- rf_addr  out  ADDR_W  register file write index (registered).
- rf_data  out  DATA_W  register file write data (registered).
- pend_addr  in  ADDR_W  decode query index.
- pend_hit  out  1  a valid queued B write targets pend_addr.
- stall_req  out  1  request that the pipeline issue no A write (registered).
- q_count  out  log2(DEPTH)+1  queue occupancy, including killed entries.

Behaviour:
- Reset (asynchronous, reset=0):
  - rf_wr=0, rf_addr=0, rf_data=0, stall_req=0, q_count=0.
  - All entry valid bits are cleared and the wait counter is set to 0.
  - Reset mid-operation discards queued writes, and no write is issued.
- A is effective when a_wr=1 and a_addr≠0. A write to $0 is treated as no A.
- Port selection at each posedge, in priority order:
  1. A effective: rf_wr←1, rf_addr/rf_data←A.
  2. Otherwise, queue non-empty: pop the head. If the head is valid, rf_wr←1 with the head's addr/data; if it was killed, rf_wr←0.
  3. Otherwise: rf_wr←0, and rf_addr/rf_data hold their previous values.
- Latency:
  - An A write reaches rf_* one cycle later.
  - A B entry pushed at edge N can be popped at edge N+1 at the earliest, so rf_wr is high during the cycle after that edge.
- b_ready = (q_count≠DEPTH). It depends only on registered state; there is no same-cycle pop bypass.
- B accept with b_addr=0: the handshake completes, but nothing is enqueued.
- Push and pop in the same cycle leave q_count unchanged. The queue is FIFO with wrap-around pointers.
- Kill rule:
  - At an edge with an effective A, every queued entry present before that edge whose addr equals a_addr has its valid bit cleared. That entry is stale and must never be written.
  - A B entry pushed at the same edge as an A write to the same addr is newer and stays valid.
- pend_hit is combinational: 1 when pend_addr≠0 and any valid entry's addr equals pend_addr.
- Wait counter:
  - Resets to 0 on a pop or when the queue is empty.
  - Otherwise increments, saturating at STARVE.
- stall_req←1 when the next-state q_count equals DEPTH, or the next-state wait counter is ≥ STARVE. Otherwise stall_req←0.
- Queue entries hold addr, data and a valid bit. Killed entries still occupy their slots until popped.

Test Plan:
- A only: a_wr=1, a_addr=3, a_data=0x11 for one cycle -> next cycle rf_wr=1, rf_addr=3, rf_data=0x11; following cycle rf_wr=0.
- B drain with A idle: push (4,0xA),(6,0xB),(7,0xC) on consecutive cycles -> rf_wr=1 for 3 consecutive cycles in order 4,6,7, each one cycle after its push; q_count returns to 0.
- Full and A priority: A writes every cycle to addr 9 while B pushes 4 entries to addr 10..13 -> b_ready=0 after the 4th push, stall_req=1; A then idles -> 4 writes of 10..13 in order, b_ready=1 after the first pop.
- Kill: A busy; push (5,0xAA); next cycle A writes (5,0xBB) -> pend_hit(5) goes 1 then 0; rf never sees 0xAA; final write to 5 is 0xBB; the killed pop gives rf_wr=0 and q_count decrements.
- Starvation: push 1 entry; A writes (addr 2) for 8 consecutive cycles -> stall_req=1 after the 8th; A idle -> pop, stall_req=0 next cycle.
- Reset mid-drain: 3 entries queued; reset low for 1 cycle -> rf_wr=0, q_count=0, b_ready=1, pend_hit=0; no queued write appears after reset release.
